// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
//   Register-mapped UART with TX/RX FIFOs, configurable character width,
//   optional parity, one or two stop bits, sticky error flags and a level
//   interrupt. All logic runs on the rising edge of clk.
//
// Parameters
//   DATA_BITS   character width, 5..9
//   FIFO_DEPTH  entries per FIFO, power of two, >= 2
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   address     register select (0 BAUD_DIV, 1 CTRL, 2 TX_DATA, 3 RX_DATA,
//               4 STATUS, 5 LEVELS, 6/7 reserved)
//   write_data  write payload, sampled when we=1
//   we, re      single-cycle write / read strobes
//   read_data   registered read data, valid the edge after re
//   tx          serial output, idle high
//   rx          serial input, asynchronous
//   irq         level interrupt
module uart_fifo_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  address,
    input  logic [31:0] write_data,
    input  logic        we,
    input  logic        re,
    output logic [31:0] read_data,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    // Configuration and sticky flags
    logic [15:0] baud_div_q, baud_div_d;
    logic        tx_en_q, tx_en_d, rx_en_q, rx_en_d, par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d, stop2_q, stop2_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic [31:0] read_data_q, read_data_d, rd_mux;

    // FIFOs
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_push_ok, tx_pop, rx_push_ok, rx_pop_ok, tx_flush, rx_flush;

    // TX engine
    state_e               tx_state_q, tx_state_d;
    logic [15:0]          tx_bcnt_q, tx_bcnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_stop2nd_q, tx_stop2nd_d;
    logic                 tx_q, tx_d, tx_busy, tx_load;

    // RX engine
    state_e               rx_state_q, rx_state_d;
    logic [15:0]          rx_bcnt_q, rx_bcnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_push_q, rx_push_d, rx_par_set, rx_frm_set;

    logic        wr_baud, wr_ctrl, wr_stat, rd_rx;
    logic [15:0] div_eff;
    logic        unused_wdata;

    assign unused_wdata = ^write_data[31:16];

    assign wr_baud  = we && (address == 3'd0);
    assign wr_ctrl  = we && (address == 3'd1);
    assign tx_push  = we && (address == 3'd2);
    assign wr_stat  = we && (address == 3'd4);
    assign rd_rx    = re && (address == 3'd3);
    assign tx_flush = wr_ctrl && write_data[5];
    assign rx_flush = wr_ctrl && write_data[6];

    // Divisors below 3 leave too few cycles for the half-bit RX alignment.
    assign div_eff = (baud_div_q < 16'd3) ? 16'd3 : baud_div_q;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));

    // Full/empty come from the pre-edge count, so a push into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign tx_push_ok = tx_push && !tx_full;
    assign rx_push_ok = rx_push_q && !rx_full;
    assign rx_pop_ok  = rd_rx && !rx_empty;

    assign tx_busy   = (tx_state_q != S_IDLE);
    assign tx        = tx_q;
    assign read_data = read_data_q;
    assign irq       = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty & ~tx_busy);

    always_comb begin
        baud_div_d = baud_div_q;
        tx_en_d    = tx_en_q;
        rx_en_d    = rx_en_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        rx_ie_d    = rx_ie_q;
        tx_ie_d    = tx_ie_q;
        if (wr_baud) begin
            baud_div_d = write_data[15:0];
        end
        if (wr_ctrl) begin
            tx_en_d   = write_data[0];
            rx_en_d   = write_data[1];
            par_en_d  = write_data[2];
            par_odd_d = write_data[3];
            stop2_d   = write_data[4];
            rx_ie_d   = write_data[7];
            tx_ie_d   = write_data[8];
        end
        // A new error event wins over a simultaneous write-one-to-clear.
        tx_ovf_d  = (tx_ovf_q  & ~(wr_stat & write_data[5])) | (tx_push & tx_full);
        rx_ovr_d  = (rx_ovr_q  & ~(wr_stat & write_data[6])) | (rx_push_q & rx_full);
        par_err_d = (par_err_q & ~(wr_stat & write_data[7])) | rx_par_set;
        frm_err_d = (frm_err_q & ~(wr_stat & write_data[8])) | rx_frm_set;
    end

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop);
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop_ok);
        if (tx_push_ok) tx_wp_d = tx_wp_q + 1'b1;
        if (tx_pop)     tx_rp_d = tx_rp_q + 1'b1;
        if (rx_push_ok) rx_wp_d = rx_wp_q + 1'b1;
        if (rx_pop_ok)  rx_rp_d = rx_rp_q + 1'b1;
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = {16'd0, baud_div_q};
            3'd1: rd_mux = {23'd0, tx_ie_q, rx_ie_q, 2'b00, stop2_q, par_odd_q,
                            par_en_q, rx_en_q, tx_en_q};
            3'd3: if (!rx_empty) rd_mux = 32'(rx_mem[rx_rp_q]);
            3'd4: rd_mux = {23'd0, frm_err_q, par_err_q, rx_ovr_q, tx_ovf_q, tx_busy,
                            rx_full, rx_empty, tx_full, tx_empty};
            3'd5: rd_mux = {16'(rx_cnt_q), 16'(tx_cnt_q)};
            default: rd_mux = '0;
        endcase
        read_data_d = re ? rd_mux : read_data_q;
    end

    // TX: the pin is registered from the current state's line level, so the
    // start bit appears one edge after the pop that enters START.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_bcnt_d    = tx_bcnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        tx_stop2nd_d = tx_stop2nd_q;
        tx_load      = 1'b0;
        tx_pop       = 1'b0;
        if (tx_state_q != S_IDLE && tx_bcnt_q != 16'd0) begin
            tx_bcnt_d = tx_bcnt_q - 16'd1;
        end
        case (tx_state_q)
            S_IDLE: tx_load = tx_en_q && !tx_empty;
            S_START: if (tx_bcnt_q == 16'd0) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
                tx_bcnt_d  = div_eff;
            end
            S_DATA: if (tx_bcnt_q == 16'd0) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bcnt_d  = div_eff;
                if (tx_bit_q == BIT_LAST) begin
                    tx_state_d   = par_en_q ? S_PARITY : S_STOP;
                    tx_stop2nd_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            S_PARITY: if (tx_bcnt_q == 16'd0) begin
                tx_state_d   = S_STOP;
                tx_bcnt_d    = div_eff;
                tx_stop2nd_d = 1'b0;
            end
            S_STOP: if (tx_bcnt_q == 16'd0) begin
                if (stop2_q && !tx_stop2nd_q) begin
                    tx_stop2nd_d = 1'b1;
                    tx_bcnt_d    = div_eff;
                end else begin
                    tx_state_d = S_IDLE;
                    // Chain straight into the next frame with no idle gap.
                    tx_load    = tx_en_q && !tx_empty;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_bcnt_d  = div_eff;
            tx_shift_d = tx_mem[tx_rp_q];
            tx_par_d   = (^tx_mem[tx_rp_q]) ^ par_odd_q;
        end
        case (tx_state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_q[0];
            S_PARITY: tx_d = tx_par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // RX: falling edge -> half-bit wait to reach mid-start, then full-bit
    // sampling; the push is issued from a flop one cycle after the stop sample.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_d  = 1'b0;
        rx_par_set = 1'b0;
        rx_frm_set = 1'b0;
        if (rx_state_q != S_IDLE && rx_bcnt_q != 16'd0) begin
            rx_bcnt_d = rx_bcnt_q - 16'd1;
        end
        if (!rx_en_q) begin
            rx_state_d = S_IDLE;
        end else begin
            case (rx_state_q)
                S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_bcnt_d  = div_eff >> 1;
                end
                S_START: if (rx_bcnt_q == 16'd0) begin
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_bit_d   = '0;
                        rx_bcnt_d  = div_eff;
                    end
                end
                S_DATA: if (rx_bcnt_q == 16'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bcnt_d  = div_eff;
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
                S_PARITY: if (rx_bcnt_q == 16'd0) begin
                    rx_par_set = (rx_s2_q != ((^rx_shift_q) ^ par_odd_q));
                    rx_state_d = S_STOP;
                    rx_bcnt_d  = div_eff;
                end
                S_STOP: if (rx_bcnt_q == 16'd0) begin
                    rx_state_d = S_IDLE;
                    rx_push_d  = rx_s2_q;
                    rx_frm_set = !rx_s2_q;
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp_q] <= write_data[DATA_BITS-1:0];
        if (rx_push_ok) rx_mem[rx_wp_q] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_q   <= '0;
            tx_en_q      <= 1'b0;
            rx_en_q      <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            rx_ie_q      <= 1'b0;
            tx_ie_q      <= 1'b0;
            tx_ovf_q     <= 1'b0;
            rx_ovr_q     <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            read_data_q  <= '0;
            tx_wp_q      <= '0;
            tx_rp_q      <= '0;
            tx_cnt_q     <= '0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
            rx_cnt_q     <= '0;
            tx_state_q   <= S_IDLE;
            tx_bcnt_q    <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_stop2nd_q <= 1'b0;
            tx_q         <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_bcnt_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_push_q    <= 1'b0;
        end else begin
            baud_div_q   <= baud_div_d;
            tx_en_q      <= tx_en_d;
            rx_en_q      <= rx_en_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            stop2_q      <= stop2_d;
            rx_ie_q      <= rx_ie_d;
            tx_ie_q      <= tx_ie_d;
            tx_ovf_q     <= tx_ovf_d;
            rx_ovr_q     <= rx_ovr_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            read_data_q  <= read_data_d;
            tx_wp_q      <= tx_wp_d;
            tx_rp_q      <= tx_rp_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wp_q      <= rx_wp_d;
            rx_rp_q      <= rx_rp_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_state_q   <= tx_state_d;
            tx_bcnt_q    <= tx_bcnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_stop2nd_q <= tx_stop2nd_d;
            tx_q         <= tx_d;
            rx_state_q   <= rx_state_d;
            rx_bcnt_q    <= rx_bcnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_push_q    <= rx_push_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] write_data = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] read_data;
    logic        tx;
    logic        rx;
    logic        irq;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;

    int total = 0;
    int bad = 0;

    assign rx = loop ? tx : rx_drv;

    uart_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .we(we), .re(re), .read_data(read_data), .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; write_data = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = read_data;
    endtask

    task automatic do_reset();
        we = 1'b0; re = 1'b0; loop = 1'b0; rx_drv = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one 8-bit frame with explicit parity and stop levels, bit period 10.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (10) @(negedge clk);
        end
        rx_drv = pbit;
        repeat (10) @(negedge clk);
        rx_drv = sbit;
        repeat (10) @(negedge clk);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  a5;
        logic        seen_low;
        a5 = 8'hA5;

        // Reset state
        do_reset();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        rd(3'd4, v); check("rst_status", v, 32'h5);
        repeat (3) @(negedge clk);
        check("rdata_hold", read_data, 32'h5);
        rd(3'd3, v); check("rx_empty_read", v, 32'd0);
        wr(3'd0, 32'h1234);
        rd(3'd0, v); check("baud_rb", v, 32'h1234);
        rd(3'd6, v); check("reg6_zero", v, 32'd0);
        wr(3'd1, 32'h100);
        check("irq_tx_ie", {31'd0, irq}, 32'd1);
        rd(3'd1, v); check("ctrl_rb", v, 32'h100);
        wr(3'd1, 32'h0);
        check("irq_off", {31'd0, irq}, 32'd0);

        // TX waveform of 0xA5 at 10 cycles per bit
        wr(3'd0, 32'd9);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'hA5);
        @(negedge clk); check("tx_pre_start", {31'd0, tx}, 32'd1);
        @(negedge clk); check("tx_start_edge", {31'd0, tx}, 32'd0);
        repeat (5) @(negedge clk); check("tx_start_mid", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            check($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, a5[i]});
        end
        repeat (10) @(negedge clk); check("tx_stop", {31'd0, tx}, 32'd1);
        repeat (4) @(negedge clk);
        rd(3'd4, v); check("tx_done_status", v, 32'h5);

        // Loopback, odd parity, two stop bits
        wr(3'd0, 32'd7);
        loop = 1'b1;
        wr(3'd1, 32'h1F);
        wr(3'd2, 32'h00);
        wr(3'd2, 32'hFF);
        wr(3'd2, 32'h3C);
        repeat (450) @(negedge clk);
        rd(3'd5, v); check("lb_levels", v, 32'h0003_0000);
        rd(3'd3, v); check("lb_rx0", v, 32'h00);
        rd(3'd3, v); check("lb_rx1", v, 32'hFF);
        rd(3'd3, v); check("lb_rx2", v, 32'h3C);
        rd(3'd4, v); check("lb_status", v, 32'h5);

        // TX overflow with the transmitter disabled, then flush
        do_reset();
        for (int i = 0; i < 17; i++) wr(3'd2, i);
        rd(3'd5, v); check("ovf_levels", v, 32'h10);
        rd(3'd4, v); check("ovf_status", v, 32'h26);
        wr(3'd4, 32'h20);
        rd(3'd4, v); check("ovf_w1c", v, 32'h06);
        wr(3'd1, 32'h20);
        rd(3'd5, v); check("flush_levels", v, 32'h0);
        rd(3'd1, v); check("flush_reads0", v, 32'h0);

        // RX error handling, even parity, bit period 10
        do_reset();
        wr(3'd0, 32'd9);
        wr(3'd1, 32'h6);
        send_frame(8'h5A, ~(^8'h5A), 1'b1);
        rd(3'd4, v); check("par_status", v, 32'h81);
        rd(3'd3, v); check("par_data", v, 32'h5A);
        wr(3'd4, 32'h80);
        send_frame(8'h33, ^8'h33, 1'b0);
        rd(3'd4, v); check("frm_status", v, 32'h105);
        rd(3'd5, v); check("frm_levels", v, 32'h0);
        wr(3'd4, 32'h100);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        rd(3'd4, v); check("glitch_status", v, 32'h5);
        for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), ^(8'(8'h10 + i)), 1'b1);
        rd(3'd5, v); check("ovr_levels", v, 32'h0010_0000);
        rd(3'd4, v); check("ovr_status", v, 32'h49);
        rd(3'd3, v); check("ovr_head", v, 32'h10);

        // Reset during a frame
        do_reset();
        wr(3'd0, 32'd9);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h00);
        repeat (30) @(negedge clk);
        check("midframe_low", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_tx_async", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx == 1'b0) seen_low = 1'b1;
        end
        check("no_residual", {31'd0, seen_low}, 32'd0);
        rd(3'd4, v); check("post_rst_status", v, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
